muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit with its own Hi/Lo result registers, producing one result bit per clock. It replaces the single-cycle ALU-Hi → Hi/Lo register path in the multicycle datapath. The control unit issues start/op, waits on busy/done, and reads hi/lo for MFHI/MFLO. It also supports direct MTHI/MTLO writes and signed/unsigned MULT/DIV.

---
 rtl/muldiv_unit.sv | 176 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with private hi/lo registers.
// One product/quotient bit per clock; sign fix-up in a final cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               res_neg;
  logic               rem_neg;
  logic               dz;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   raw_a;
  logic [2*WIDTH-1:0] work;

  logic               op_signed;
  logic               op_div;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               launch;
  logic               wr_ok;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] mul_nx;
  logic [2*WIDTH-1:0] div_nx;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign op_signed = ~op[0];
  assign op_div    = op[1];
  assign a_neg     = op_signed & a[WIDTH-1];
  assign b_neg     = op_signed & b[WIDTH-1];
  assign abs_a     = a_neg ? -a : a;
  assign abs_b     = b_neg ? -b : b;

  assign launch = (state == S_IDLE) & start;
  assign wr_ok  = (state == S_IDLE) | (state == S_DONE);

  assign busy        = (state == S_CALC) | (state == S_FIX);
  assign done        = (state == S_DONE);
  assign div_by_zero = (state == S_DONE) & dz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (start) state_n = S_CALC;
      S_CALC: if (cnt == CNT_W'(1)) state_n = S_FIX;
      S_FIX:  state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // work = {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    add_sum = {1'b0, work[2*WIDTH-1:WIDTH]}
            + (work[0] ? {1'b0, mag_a} : '0);
    mul_nx  = {add_sum, work[WIDTH-1:1]};
    rem_sh  = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    diff    = rem_sh - {1'b0, mag_b};
    if (diff[WIDTH]) begin
      div_nx = {rem_sh[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
    end else begin
      div_nx = {diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    prod   = res_neg ? -work : work;
    quo    = work[WIDTH-1:0];
    rem    = work[2*WIDTH-1:WIDTH];
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    unique case (1'b1)
      is_div & dz: begin
        res_hi = raw_a;
        res_lo = '1;
      end
      is_div & ~dz: begin
        res_hi = rem_neg ? -rem : rem;
        res_lo = res_neg ? -quo : quo;
      end
      ~is_div: begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
      end
      default: begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      is_div  <= 1'b0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      dz      <= 1'b0;
      mag_a   <= '0;
      mag_b   <= '0;
      raw_a   <= '0;
      work    <= '0;
    end else if (launch) begin
      cnt     <= CNT_W'(WIDTH);
      is_div  <= op_div;
      res_neg <= a_neg ^ b_neg;
      rem_neg <= a_neg;
      dz      <= op_div & (b == '0);
      mag_a   <= abs_a;
      mag_b   <= abs_b;
      raw_a   <= a;
      work    <= {{WIDTH{1'b0}}, op_div ? abs_a : abs_b};
    end else if (state == S_CALC) begin
      cnt  <= cnt - CNT_W'(1);
      work <= is_div ? div_nx : mul_nx;
    end
  end

  // In DONE the result is already loaded, so a same-cycle MTHI/MTLO wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == S_FIX) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (wr_ok) begin
      if (hi_wr) hi <= wdata;
      if (lo_wr) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised bench for muldiv_unit at WIDTH 32 and 8.
// Results are compared with an integer-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32;
  logic        start8;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_wr;
  logic        lo_wr;
  logic [31:0] wdata;

  logic        busy32, done32, dz32;
  logic [31:0] hi32, lo32;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int n_run  = 0;
  int n_fail = 0;

  logic [31:0] eh32;
  logic [31:0] el32;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op),
    .a(a), .b(b), .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
    .busy(busy32), .done(done32), .div_by_zero(dz32),
    .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op),
    .a(a[7:0]), .b(b[7:0]), .hi_wr(hi_wr), .lo_wr(lo_wr),
    .wdata(wdata[7:0]),
    .busy(busy8), .done(done8), .div_by_zero(dz8),
    .hi(hi8), .lo(lo8)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input int w, input logic [1:0] o,
                                input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh,
                                output logic [31:0] el,
                                output logic ed);
    logic [63:0] m, ux, uy, p;
    longint sx, sy, q, r;
    m  = (64'd1 << w) - 64'd1;
    ux = {32'd0, x} & m;
    uy = {32'd0, y} & m;
    sx = ux[w-1] ? $signed(ux) - $signed(m) - 64'sd1 : $signed(ux);
    sy = uy[w-1] ? $signed(uy) - $signed(m) - 64'sd1 : $signed(uy);
    ed = 1'b0;
    p  = '0;
    case (o)
      2'b00: p = $unsigned(sx * sy);
      2'b01: p = ux * uy;
      default: begin
        if (uy == 64'd0) begin
          ed = 1'b1;
          p  = (ux << w) | m;
        end else begin
          if (o == 2'b10) begin
            q = sx / sy;
            r = sx % sy;
          end else begin
            q = $signed(ux / uy);
            r = $signed(ux % uy);
          end
          p = (($unsigned(r) & m) << w) | ($unsigned(q) & m);
        end
      end
    endcase
    eh = 32'((p >> w) & m);
    el = 32'(p & m);
  endfunction

  function automatic logic [31:0] cur_hi(input int w);
    return (w == 32) ? hi32 : {24'd0, hi8};
  endfunction

  function automatic logic [31:0] cur_lo(input int w);
    return (w == 32) ? lo32 : {24'd0, lo8};
  endfunction

  task automatic run(input int w, input logic [1:0] o,
                     input logic [31:0] x, input logic [31:0] y,
                     input bit disturb, input bit wr_done);
    logic [31:0] eh, el, wv;
    logic ed, d;
    int lat;
    model(w, o, x, y, eh, el, ed);
    op = o;
    a  = x;
    b  = y;
    if (w == 32) start32 = 1'b1;
    else start8 = 1'b1;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    start8  = 1'b0;
    check("busy_start",
          64'((w == 32) ? busy32 : busy8), 64'd1);
    op  = 2'($urandom);
    a   = $urandom;
    b   = $urandom;
    lat = 0;
    d   = 1'b0;
    while (!d && lat < 100) begin
      if (disturb && lat >= 5 && lat <= 10) begin
        start32 = 1'b1;
        hi_wr   = 1'b1;
        wdata   = 32'hDEAD;
        a       = $urandom;
      end else begin
        start32 = 1'b0;
        hi_wr   = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      d = (w == 32) ? done32 : done8;
    end
    start32 = 1'b0;
    hi_wr   = 1'b0;
    check("latency", 64'(lat), 64'(w + 1));
    check("busy_done", 64'((w == 32) ? busy32 : busy8), 64'd0);
    check("hi", 64'(cur_hi(w)), 64'(eh));
    check("lo", 64'(cur_lo(w)), 64'(el));
    check("dz", 64'((w == 32) ? dz32 : dz8), 64'(ed));
    wv = 32'h5A5A0F0F & ((w == 32) ? 32'hFFFFFFFF : 32'hFF);
    if (wr_done) begin
      hi_wr = 1'b1;
      wdata = 32'h5A5A0F0F;
    end
    @(posedge clk);
    #1;
    hi_wr = 1'b0;
    check("done_fall", 64'((w == 32) ? done32 : done8), 64'd0);
    check("dz_fall", 64'((w == 32) ? dz32 : dz8), 64'd0);
    if (wr_done) eh = wv;
    check("hi_hold", 64'(cur_hi(w)), 64'(eh));
    check("lo_hold", 64'(cur_lo(w)), 64'(el));
    if (w == 32) begin
      eh32 = eh;
      el32 = el;
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset   = 1'b0;
    start32 = 1'b0;
    start8  = 1'b0;
    op      = 2'b00;
    a       = '0;
    b       = '0;
    hi_wr   = 1'b0;
    lo_wr   = 1'b0;
    wdata   = '0;
    eh32    = '0;
    el32    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy32), 64'd0);
    check("rst_done", 64'(done32), 64'd0);
    check("rst_dz", 64'(dz32), 64'd0);
    check("rst_hi", 64'(hi32), 64'd0);
    check("rst_lo", 64'(lo32), 64'd0);
    check("rst_hi8", 64'(hi8), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    run(32, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    check("multu_max_hi", 64'(hi32), 64'hFFFFFFFE);
    run(32, 2'b00, 32'hFFFFFFFD, 32'd7, 0, 0);
    run(32, 2'b10, 32'hFFFFFFF9, 32'd2, 0, 0);
    check("div_neg_lo", 64'(lo32), 64'hFFFFFFFD);
    run(32, 2'b11, 32'h12345678, 32'd0, 0, 0);
    run(32, 2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    run(32, 2'b11, 32'd100, 32'd7, 1, 0);

    lo_wr = 1'b1;
    wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    lo_wr = 1'b0;
    check("mtlo_lo", 64'(lo32), 64'hCAFEF00D);
    check("mtlo_hi", 64'(hi32), 64'(eh32));
    run(32, 2'b01, 32'd2, 32'd3, 0, 0);
    run(32, 2'b10, $urandom, $urandom | 32'd1, 0, 1);

    hi_wr = 1'b1;
    wdata = 32'h1234;
    @(posedge clk);
    #1;
    hi_wr = 1'b0;
    check("mthi_hi", 64'(hi32), 64'h1234);
    op      = 2'b00;
    a       = $urandom;
    b       = $urandom;
    start32 = 1'b1;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy32), 64'd0);
    check("arst_done", 64'(done32), 64'd0);
    check("arst_hi", 64'(hi32), 64'd0);
    check("arst_lo", 64'(lo32), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_busy", 64'(busy32), 64'd0);
    run(32, 2'b01, 32'd5, 32'd5, 0, 0);

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: ra = 32'h80000000;
        default: ;
      endcase
      run(32, 2'($urandom), ra, rb, 0, 0);
    end

    run(8, 2'b01, 32'hFF, 32'hFF, 0, 0);
    check("multu8_hi", 64'(hi8), 64'hFE);
    run(8, 2'b00, 32'hFD, 32'h07, 0, 0);
    run(8, 2'b10, 32'hF9, 32'h02, 0, 0);
    run(8, 2'b11, 32'h12, 32'h00, 0, 0);
    run(8, 2'b10, 32'h80, 32'hFF, 0, 0);
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'hFF;
        2: ra = 32'h80;
        default: ;
      endcase
      run(8, 2'($urandom), ra, rb, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
